wb_arbiter: RTL and testbench

- Writeback arbiter and write-port driver for the 64-entry integer/FP register file.
- Collects results from N_SRC execution units (ALU, MUL/DIV, FPU, LSU) over valid/ready handshakes and buffers one result per source.
- Selects one result per cycle round-robin and drives the file's single write port (rd_wena/rd_addr/rd_data) from registers.
- Exports a pending-write mask for the issue-stage hazard logic.

---
 rtl/wb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/wb_arbiter.sv | 112 +++++++++++
 tb/tb_wb_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback types and constants for the register-file write path.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 6;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] onehot_addr(input logic [REG_ADDR_W-1:0] addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a
// registered pointer; the pointer moves past the winner when advanced.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         i_req,
    input  logic                 i_advance,
    output logic [N-1:0]         o_grant_c,
    output logic [$clog2(N)-1:0] o_gidx_c
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    int unsigned      w_sum;
    logic             w_found;

    // First requester at or after r_ptr, wrapping N-1 -> 0
    always_comb begin
        o_grant_c = '0;
        o_gidx_c  = '0;
        w_found   = 1'b0;
        w_sum     = 0;
        w_idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_sum = 32'(r_ptr) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = IDX_W'(w_sum);
            if (!w_found && i_req[w_idx]) begin
                o_grant_c[w_idx] = 1'b1;
                o_gidx_c         = w_idx;
                w_found          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_gidx_c == IDX_W'(N - 1)) ? '0 : o_gidx_c + IDX_W'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one result buffer per execution unit, round-robin
// selection onto the registered register-file write port, pending-write mask.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = XLEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         src_valid,
    output logic [N_SRC-1:0]         src_ready,
    input  logic [N_SRC*ADDR_W-1:0]  src_addr,
    input  logic [N_SRC*DATA_W-1:0]  src_data,
    output logic                     rd_wena,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [(2**ADDR_W)-1:0]   pend_mask
);

    localparam int unsigned IDX_W = $clog2(N_SRC);
    localparam int unsigned NREG  = 1 << ADDR_W;

    logic [N_SRC-1:0]  r_buf_v;
    logic [ADDR_W-1:0] r_buf_addr [N_SRC];
    logic [DATA_W-1:0] r_buf_data [N_SRC];
    logic              r_wena;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic [N_SRC-1:0]  w_grant;
    logic [IDX_W-1:0]  w_gidx;
    logic [N_SRC-1:0]  w_load;
    logic [NREG-1:0]   w_pend;

    rr_arbiter #(.N(N_SRC)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .i_req     (r_buf_v),
        .i_advance (|w_grant),
        .o_grant_c (w_grant),
        .o_gidx_c  (w_gidx)
    );

    // A buffer can take a new result when empty or being drained this cycle
    assign src_ready = ~r_buf_v | w_grant;

    // Writes to the zero register are acknowledged but dropped
    always_comb begin
        w_load = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            w_load[i] = src_valid[i] & src_ready[i] & (src_addr[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_v <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (w_load[i]) begin
                    r_buf_v[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_buf_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (w_load[i]) begin
                r_buf_addr[i] <= src_addr[i*ADDR_W +: ADDR_W];
                r_buf_data[i] <= src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Registered write port; address/data hold when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wena <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (|w_grant) begin
            r_wena <= 1'b1;
            r_addr <= r_buf_addr[w_gidx];
            r_data <= r_buf_data[w_gidx];
        end else begin
            r_wena <= 1'b0;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (r_buf_v[i]) begin
                w_pend = w_pend | (NREG'(1) << r_buf_addr[i]);
            end
        end
        if (r_wena) begin
            w_pend = w_pend | (NREG'(1) << r_addr);
        end
    end

    assign rd_wena   = r_wena;
    assign rd_addr   = r_addr;
    assign rd_data   = r_data;
    assign pend_mask = w_pend;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus multi-cycle sequences,
// with a per-address scoreboard matching every accepted result to its write.
module tb_wb_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   src_valid;
    logic [3:0]   src_ready;
    logic [23:0]  src_addr;
    logic [127:0] src_data;
    logic         rd_wena;
    logic [5:0]   rd_addr;
    logic [31:0]  rd_data;
    logic [63:0]  pend_mask;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct packed {
        logic [3:0]   valid;
        logic [23:0]  addr;
        logic [127:0] data;
        logic [3:0]   exp_ready;
        logic         exp_wena;
        logic [5:0]   exp_addr;
        logic [31:0]  exp_data;
        logic [63:0]  exp_pend;
    } vec_t;
    vec_t vecs[13];

    wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .rd_wena   (rd_wena),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ob(input int k);
        return 64'(1) << k;
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [23:0] a, input logic [127:0] d,
                                input logic [3:0] r, input logic w, input logic [5:0] ea,
                                input logic [31:0] ed, input logic [63:0] ep);
        vec_t t;
        t.valid = v; t.addr = a; t.data = d; t.exp_ready = r;
        t.exp_wena = w; t.exp_addr = ea; t.exp_data = ed; t.exp_pend = ep;
        return t;
    endfunction

    // Scoreboard: match writes by address (oldest first), push accepted results
    task automatic monitor();
        int  idx;
        bit  found;
        if (reset) begin
            sb.delete();
        end else begin
            if (rd_wena) begin
                found = 1'b0;
                idx   = 0;
                for (int j = 0; j < sb.size(); j++) begin
                    if (!found && sb[j].addr == rd_addr) begin
                        found = 1'b1;
                        idx   = j;
                    end
                end
                checks++;
                if (!found) begin
                    failures++;
                    $display("FAIL sb_unexpected_write: got addr %0d data %0h expected no write", rd_addr, rd_data);
                end else begin
                    check($sformatf("sb_data addr%0d", rd_addr), 64'(rd_data), 64'(sb[idx].data));
                    sb.delete(idx);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (src_valid[i] && src_ready[i] && src_addr[i*6 +: 6] != 6'd0) begin
                    sb.push_back('{addr: src_addr[i*6 +: 6], data: src_data[i*32 +: 32]});
                end
            end
            for (int i = 0; i < 4; i++) begin
                for (int j = i + 1; j < 4; j++) begin
                    if (dut.r_buf_v[i] && dut.r_buf_v[j] && dut.r_buf_addr[i] != 6'd0) begin
                        check($sformatf("dup_buf_addr %0d/%0d", i, j),
                              64'(dut.r_buf_addr[i] == dut.r_buf_addr[j]), 64'(0));
                    end
                end
            end
        end
    endtask

    task automatic to_negedge();
        @(negedge clk);
        monitor();
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
    endtask

    task automatic set_src(input int i, input logic [5:0] a, input logic [31:0] d);
        src_valid[i]       = 1'b1;
        src_addr[i*6 +: 6] = a;
        src_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        sb.delete();
        repeat (2) @(posedge clk);
        to_negedge();
        check("reset rd_wena", 64'(rd_wena), 64'(0));
        check("reset rd_addr", 64'(rd_addr), 64'(0));
        check("reset rd_data", 64'(rd_data), 64'(0));
        check("reset pend_mask", pend_mask, 64'(0));
        check("reset src_ready", 64'(src_ready), 64'hF);
        to_next();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();

        vecs[0]  = mk(4'b0010, {6'd0, 6'd0, 6'd5, 6'd0}, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
                      4'hF, 1'b0, 6'd0, 32'h0, 64'h0);
        vecs[1]  = mk(4'b0000, '0, '0, 4'hF, 1'b0, 6'd0, 32'h0, ob(5));
        vecs[2]  = mk(4'b0000, '0, '0, 4'hF, 1'b1, 6'd5, 32'hDEADBEEF, ob(5));
        vecs[3]  = mk(4'b0000, '0, '0, 4'hF, 1'b0, 6'd5, 32'hDEADBEEF, 64'h0);
        vecs[4]  = mk(4'b0001, '0, {96'h0, 32'h12345678}, 4'hF, 1'b0, 6'd5, 32'hDEADBEEF, 64'h0);
        vecs[5]  = mk(4'b0000, '0, '0, 4'hF, 1'b0, 6'd5, 32'hDEADBEEF, 64'h0);
        vecs[6]  = mk(4'b0000, '0, '0, 4'hF, 1'b0, 6'd5, 32'hDEADBEEF, 64'h0);
        vecs[7]  = mk(4'b1000, {6'd11, 18'd0}, {32'hA3A3A3A3, 96'h0},
                      4'hF, 1'b0, 6'd5, 32'hDEADBEEF, 64'h0);
        vecs[8]  = mk(4'b1001, {6'd13, 6'd0, 6'd0, 6'd12}, {32'hB3B3B3B3, 64'h0, 32'hA0A0A0A0},
                      4'hF, 1'b0, 6'd5, 32'hDEADBEEF, ob(11));
        vecs[9]  = mk(4'b0000, '0, '0, 4'b0111, 1'b1, 6'd11, 32'hA3A3A3A3, ob(11) | ob(12) | ob(13));
        vecs[10] = mk(4'b0000, '0, '0, 4'hF, 1'b1, 6'd12, 32'hA0A0A0A0, ob(12) | ob(13));
        vecs[11] = mk(4'b0000, '0, '0, 4'hF, 1'b1, 6'd13, 32'hB3B3B3B3, ob(13));
        vecs[12] = mk(4'b0000, '0, '0, 4'hF, 1'b0, 6'd13, 32'hB3B3B3B3, 64'h0);

        // Single write, zero-register write, pointer wrap
        do_reset();
        for (int v = 0; v < 13; v++) begin
            src_valid = vecs[v].valid;
            src_addr  = vecs[v].addr;
            src_data  = vecs[v].data;
            to_negedge();
            check($sformatf("vec%0d src_ready", v), 64'(src_ready), 64'(vecs[v].exp_ready));
            check($sformatf("vec%0d rd_wena", v), 64'(rd_wena), 64'(vecs[v].exp_wena));
            check($sformatf("vec%0d rd_addr", v), 64'(rd_addr), 64'(vecs[v].exp_addr));
            check($sformatf("vec%0d rd_data", v), 64'(rd_data), 64'(vecs[v].exp_data));
            check($sformatf("vec%0d pend_mask", v), pend_mask, vecs[v].exp_pend);
            to_next();
        end

        // Four-way contention from reset
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive_idle();
            for (int i = 0; i < 4; i++) set_src(i, 6'(i + 1), {8'(i), 24'(c)});
            to_negedge();
            check($sformatf("rr c%0d src_ready", c), 64'(src_ready),
                  (c == 0) ? 64'hF : ob((c - 1) % 4));
            check($sformatf("rr c%0d rd_wena", c), 64'(rd_wena), 64'(c >= 2));
            if (c >= 2) check($sformatf("rr c%0d rd_addr", c), 64'(rd_addr), 64'(((c - 2) % 4) + 1));
            to_next();
        end
        drive_idle();
        repeat (6) begin to_negedge(); to_next(); end

        // Streaming single source
        for (int c = 0; c < 14; c++) begin
            drive_idle();
            if (c < 10) set_src(2, 6'd7, 32'(c));
            to_negedge();
            if (c < 10) check($sformatf("stream c%0d ready2", c), 64'(src_ready[2]), 64'(1));
            check($sformatf("stream c%0d rd_wena", c), 64'(rd_wena), 64'(c >= 2 && c <= 11));
            if (c >= 2 && c <= 11) check($sformatf("stream c%0d rd_data", c), 64'(rd_data), 64'(c - 2));
            to_next();
        end

        // Reset mid-operation with a write on the port and three buffered
        drive_idle();
        set_src(1, 6'd20, 32'h20202020);
        to_negedge(); to_next();
        drive_idle();
        set_src(0, 6'd8, 32'h08080808);
        set_src(2, 6'd9, 32'h09090909);
        set_src(3, 6'd10, 32'h10101010);
        to_negedge(); to_next();
        drive_idle();
        check("midrst pre rd_wena", 64'(rd_wena), 64'(1));
        check("midrst pre rd_addr", 64'(rd_addr), 64'(20));
        check("midrst pre pend_mask", pend_mask, ob(8) | ob(9) | ob(10) | ob(20));
        #2 reset = 1'b1;
        #1;
        check("midrst async rd_wena", 64'(rd_wena), 64'(0));
        check("midrst async rd_addr", 64'(rd_addr), 64'(0));
        check("midrst async pend_mask", pend_mask, 64'(0));
        to_negedge(); to_next();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            to_negedge();
            check($sformatf("postrst c%0d rd_wena", c), 64'(rd_wena), 64'(0));
            check($sformatf("postrst c%0d pend_mask", c), pend_mask, 64'(0));
            to_next();
        end
        for (int c = 0; c < 8; c++) begin
            drive_idle();
            if (c == 0) for (int i = 0; i < 4; i++) set_src(i, 6'(21 + i), 32'(32'hC0 + i));
            to_negedge();
            check($sformatf("ptr0 c%0d rd_wena", c), 64'(rd_wena), 64'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) check($sformatf("ptr0 c%0d rd_addr", c), 64'(rd_addr), 64'(21 + c - 2));
            to_next();
        end

        check("sb drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
